// File: rtl/cu_pkg.sv
// Shared definitions for the sequential control unit: opcodes, ALU selects,
// FSM state encoding and the decoded instruction-class record.
package cu_pkg;

  // Opcode values, taken from the 5 LSBs of the opcode field.
  localparam logic [4:0] OP_NOP       = 5'd0;
  localparam logic [4:0] OP_MOV_RC    = 5'd1;   // reg -> RC
  localparam logic [4:0] OP_MOV_CONST = 5'd2;   // const -> RC
  localparam logic [4:0] OP_MOV_REG   = 5'd3;   // RC -> reg
  localparam logic [4:0] OP_MOV_RA    = 5'd4;   // reg -> RA
  localparam logic [4:0] OP_LOAD      = 5'd5;
  localparam logic [4:0] OP_STORE     = 5'd6;
  localparam logic [4:0] OP_NOT       = 5'd7;
  localparam logic [4:0] OP_AND       = 5'd8;
  localparam logic [4:0] OP_OR        = 5'd9;
  localparam logic [4:0] OP_XOR       = 5'd10;
  localparam logic [4:0] OP_ADD       = 5'd11;
  localparam logic [4:0] OP_SUB       = 5'd12;
  localparam logic [4:0] OP_INC       = 5'd13;

  // ALU function selects driven during EXEC.
  localparam int ALU_NONE = 0;
  localparam int ALU_NOT  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_ADD  = 5;
  localparam int ALU_SUB  = 6;
  localparam int ALU_INC  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Instruction classes the FSM needs to gate its controls.
  typedef struct packed {
    logic reg_to_rc;    // MOV reg->RC
    logic const_to_rc;  // MOV const->RC
    logic rc_to_reg;    // MOV RC->reg
    logic reg_to_ra;    // MOV reg->RA
    logic is_alu;       // NOT..INC
    logic is_mem;       // LOAD or STORE
    logic is_store;     // STORE
    logic is_illegal;   // undefined opcode
  } op_class_t;

endpackage

// File: rtl/cu_op_decode.sv
// Combinational opcode decoder: instruction-class flags and ALU select.
module cu_op_decode
  import cu_pkg::*;
#(
  parameter int OP_W     = 5,
  parameter int ALUSEL_W = 3
) (
  input  logic [OP_W-1:0]     opcode,
  output op_class_t           op_class,
  output logic [ALUSEL_W-1:0] alu_sel
);

  logic       upper_nz;
  logic [4:0] op5;

  // Any set bit above the 5-bit opcode space makes the instruction illegal.
  assign upper_nz = (opcode >> 5) != '0;
  assign op5      = opcode[4:0];

  // Map the opcode onto its class and ALU function.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    op_class = '0;
    alu_sel  = '0;
    if (upper_nz) begin
      op_class.is_illegal = 1'b1;
    end else begin
      case (op5)
        OP_NOP:       ;
        OP_MOV_RC:    op_class.reg_to_rc   = 1'b1;
        OP_MOV_CONST: op_class.const_to_rc = 1'b1;
        OP_MOV_REG:   op_class.rc_to_reg   = 1'b1;
        OP_MOV_RA:    op_class.reg_to_ra   = 1'b1;
        OP_LOAD:      op_class.is_mem      = 1'b1;
        OP_STORE: begin
          op_class.is_mem   = 1'b1;
          op_class.is_store = 1'b1;
        end
        OP_NOT: begin op_class.is_alu = 1'b1; alu_sel = ALUSEL_W'(ALU_NOT); end
        OP_AND: begin op_class.is_alu = 1'b1; alu_sel = ALUSEL_W'(ALU_AND); end
        OP_OR:  begin op_class.is_alu = 1'b1; alu_sel = ALUSEL_W'(ALU_OR);  end
        OP_XOR: begin op_class.is_alu = 1'b1; alu_sel = ALUSEL_W'(ALU_XOR); end
        OP_ADD: begin op_class.is_alu = 1'b1; alu_sel = ALUSEL_W'(ALU_ADD); end
        OP_SUB: begin op_class.is_alu = 1'b1; alu_sel = ALUSEL_W'(ALU_SUB); end
        OP_INC: begin op_class.is_alu = 1'b1; alu_sel = ALUSEL_W'(ALU_INC); end
        default:      op_class.is_illegal  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_unit_seq.sv
// Multi-cycle control unit: accepts instructions over valid/ready, then
// sequences datapath and memory controls through IDLE/EXEC/MEM/DONE.
module control_unit_seq
  import cu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REGSEL_W    = 3,
  parameter int ALUSEL_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   inst,
  input  logic                instValid,
  output logic                instReady,
  output logic [REGSEL_W-1:0] regSel,
  output logic [ALUSEL_W-1:0] aluSel,
  output logic                Rin,
  output logic                Rout,
  output logic                RAin,
  output logic                RCin,
  output logic                RCout,
  output logic                genConst,
  output logic                MARin,
  output logic                memReq,
  output logic                memWe,
  output logic                memOut,
  input  logic                memAck,
  output logic                busy,
  output logic                illegal,
  output logic                memErr
);

  localparam int OP_W  = DATA_W - REGSEL_W;
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   ir;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                ready_q;   // low in reset and on the first edge after it
  logic                accept;
  op_class_t           op_class;
  logic [ALUSEL_W-1:0] dec_alu;

  cu_op_decode #(
    .OP_W     (OP_W),
    .ALUSEL_W (ALUSEL_W)
  ) u_op_decode (
    .opcode   (ir[DATA_W-1:REGSEL_W]),
    .op_class (op_class),
    .alu_sel  (dec_alu)
  );

  assign instReady = (state == ST_IDLE) && ready_q;
  assign accept    = instReady && instValid;
  assign busy      = (state != ST_IDLE);

  // State, instruction register and wait counter; reset aborts any operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state   <= ST_IDLE;
      ir      <= '0;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= 1'b1;
      if (accept) ir <= inst;
    end
  end

  // Next-state logic and control decode from state and IR.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    regSel    = '0;
    aluSel    = '0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    RAin      = 1'b0;
    RCin      = 1'b0;
    RCout     = 1'b0;
    genConst  = 1'b0;
    MARin     = 1'b0;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memOut    = 1'b0;
    illegal   = 1'b0;
    memErr    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        regSel    = ir[REGSEL_W-1:0];
        aluSel    = dec_alu;
        Rout      = op_class.reg_to_rc | op_class.is_alu | op_class.reg_to_ra | op_class.is_mem;
        RCin      = op_class.reg_to_rc | op_class.is_alu | op_class.const_to_rc;
        genConst  = op_class.const_to_rc;
        RCout     = op_class.rc_to_reg;
        Rin       = op_class.rc_to_reg;
        RAin      = op_class.reg_to_ra;
        MARin     = op_class.is_mem;
        illegal   = op_class.is_illegal;
        cnt_nxt   = '0;
        state_nxt = op_class.is_mem ? ST_MEM : ST_DONE;
      end
      ST_MEM: begin
        memReq = 1'b1;
        memWe  = op_class.is_store;
        RCout  = op_class.is_store;
        if (memAck) begin
          // An ack arriving on the timeout cycle still completes normally.
          memOut    = !op_class.is_store;
          RCin      = !op_class.is_store;
          cnt_nxt   = '0;
          state_nxt = ST_DONE;
        end else if (cnt == CNT_LAST) begin
          memErr    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit_seq.sv
// Self-checking bench: per-instruction expected-output schedules built from
// the instruction rules, compared every cycle, plus directed literal checks.
module tb_control_unit_seq;

  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (DATA_W=8)
  logic       rst_n, inst_valid, mem_ack;
  logic [7:0] inst;
  logic       inst_ready, rin, rout, ra_in, rc_in, rc_out, gen_const, mar_in;
  logic       mem_req, mem_we, mem_out, busy, illegal, mem_err;
  logic [2:0] reg_sel, alu_sel;

  control_unit_seq #(.DATA_W(8), .REGSEL_W(3), .ALUSEL_W(3), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .instValid(inst_valid), .instReady(inst_ready),
    .regSel(reg_sel), .aluSel(alu_sel), .Rin(rin), .Rout(rout), .RAin(ra_in), .RCin(rc_in),
    .RCout(rc_out), .genConst(gen_const), .MARin(mar_in), .memReq(mem_req), .memWe(mem_we),
    .memOut(mem_out), .memAck(mem_ack), .busy(busy), .illegal(illegal), .memErr(mem_err)
  );

  // Wide instance (DATA_W=10, short timeout)
  logic       rst2_n, v2, ack2;
  logic [9:0] inst2;
  logic       ready2, rin2, rout2, ra2, rcin2, rcout2, gc2, mar2;
  logic       req2, we2, mout2, busy2, ill2, err2;
  logic [2:0] rs2, as2;

  control_unit_seq #(.DATA_W(10), .REGSEL_W(3), .ALUSEL_W(3), .MEM_TIMEOUT(3)) dut2 (
    .clk(clk), .rst_n(rst2_n), .inst(inst2), .instValid(v2), .instReady(ready2),
    .regSel(rs2), .aluSel(as2), .Rin(rin2), .Rout(rout2), .RAin(ra2), .RCin(rcin2),
    .RCout(rcout2), .genConst(gc2), .MARin(mar2), .memReq(req2), .memWe(we2),
    .memOut(mout2), .memAck(ack2), .busy(busy2), .illegal(ill2), .memErr(err2)
  );

  typedef struct packed {
    logic inst_ready, busy, rin, rout, ra_in, rc_in, rc_out, gen_const, mar_in;
    logic mem_req, mem_we, mem_out, illegal, mem_err;
    logic [2:0] reg_sel, alu_sel;
  } outs_t;

  typedef struct {
    outs_t o;
    int    ack;   // 0 / 1 = drive that value, 2 = random (ignored by DUT)
  } slot_t;

  slot_t sched[$];
  outs_t exp_o, got_o;
  int    n_checks = 0, n_errs = 0, cyc = 0;
  bit    chk_en = 0, idle_now = 0;

  assign got_o = {inst_ready, busy, rin, rout, ra_in, rc_in, rc_out, gen_const, mar_in,
                  mem_req, mem_we, mem_out, illegal, mem_err, reg_sel, alu_sel};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Compare every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (got_o !== exp_o) begin
        n_errs++;
        $display("FAIL cycle %0d outputs: got=%h want=%h", cyc, got_o, exp_o);
      end
    end
  end

  // Expected EXEC-cycle outputs from the instruction table.
  function automatic outs_t exec_vec(input logic [7:0] i);
    outs_t o;
    int    op;
    op = int'(i[7:3]);
    o = '0;
    o.busy = 1'b1;
    o.reg_sel = i[2:0];
    if (op == 0) begin
    end else if (op == 1) begin
      o.rout = 1; o.rc_in = 1;
    end else if (op == 2) begin
      o.gen_const = 1; o.rc_in = 1;
    end else if (op == 3) begin
      o.rc_out = 1; o.rin = 1;
    end else if (op == 4) begin
      o.rout = 1; o.ra_in = 1;
    end else if (op == 5 || op == 6) begin
      o.rout = 1; o.mar_in = 1;
    end else if (op >= 7 && op <= 13) begin
      o.rout = 1; o.rc_in = 1;
      o.alu_sel = 3'(op - 6);
    end else begin
      o.illegal = 1;
    end
    return o;
  endfunction

  // Queue the whole post-accept output sequence of one instruction.
  // w = number of wait cycles before memAck; w >= TO means no ack (timeout).
  task automatic push_op(input logic [7:0] i, input int w);
    slot_t s;
    outs_t m;
    int    op, n;
    bit    st;
    op = int'(i[7:3]);
    s.o = exec_vec(i); s.ack = 2;
    sched.push_back(s);
    if (op == 5 || op == 6) begin
      st = (op == 6);
      n  = (w < TO) ? w + 1 : TO;
      for (int k = 0; k < n; k++) begin
        m = '0;
        m.busy = 1; m.mem_req = 1; m.mem_we = st; m.rc_out = st;
        s.ack = 0;
        if (w < TO && k == w) begin
          m.mem_out = !st; m.rc_in = !st; s.ack = 1;
        end
        if (w >= TO && k == TO - 1) m.mem_err = 1;
        s.o = m;
        sched.push_back(s);
      end
    end
    s.o = '0; s.o.busy = 1; s.ack = 2;
    sched.push_back(s);
  endtask

  // Drive one edge's inputs, advance a cycle, and set up expectations.
  task automatic step(input logic v, input logic [7:0] i, input logic rst_v, input int w);
    slot_t s;
    rst_n = rst_v; inst_valid = v; inst = i;
    if (rst_v && idle_now && v) push_op(i, w);
    @(posedge clk); #1;
    cyc++;
    if (!rst_v) begin
      sched.delete();
      exp_o = '0;
      mem_ack = 1'($urandom_range(0, 1));
      idle_now = 0;
    end else if (sched.size() > 0) begin
      s = sched.pop_front();
      exp_o = s.o;
      mem_ack = (s.ack == 2) ? 1'($urandom_range(0, 1)) : 1'(s.ack);
      idle_now = 0;
    end else begin
      exp_o = '0;
      exp_o.inst_ready = 1;
      mem_ack = 1'($urandom_range(0, 1));
      idle_now = 1;
    end
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && !idle_now; k++) step(0, 8'h00, 1, 0);
    check("wait_idle", 32'(idle_now), 1);
  endtask

  // Issue a memory op and count memory-phase events until memReq drops.
  task automatic mem_op(input logic [7:0] i, input int w,
                        output int req_n, output int ack_n, output int err_n, output int rcin_n);
    wait_idle();
    step(1, i, 1, w);
    check("mem_exec_rout", 32'(rout), 1);
    check("mem_exec_marin", 32'(mar_in), 1);
    req_n = 0; ack_n = 0; err_n = 0; rcin_n = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 8'h00, 1, 0);
      if (!mem_req) break;
      req_n++;
      if (mem_out && rc_in) ack_n++;
      if (mem_err) err_n++;
      if (rc_in) rcin_n++;
    end
  endtask

  initial begin
    int req_n, ack_n, err_n, rcin_n, n;
    logic [7:0] ri;
    rst_n = 0; inst_valid = 0; inst = '0; mem_ack = 0;
    rst2_n = 0; v2 = 0; inst2 = '0; ack2 = 0;
    @(posedge clk); #1;
    exp_o = '0; #1;
    chk_en = 1;

    // Reset holds instReady low; it rises after the first released edge.
    step(0, 8'h00, 0, 0);
    check("reset_ready", 32'(inst_ready), 0);
    step(0, 8'h00, 1, 0);
    check("ready_after_reset", 32'(inst_ready), 1);

    // AND r3
    step(1, 8'b01000_011, 1, 0);
    check("and_regsel", 32'(reg_sel), 3);
    check("and_alusel", 32'(alu_sel), 2);
    check("and_rout", 32'(rout), 1);
    check("and_rcin", 32'(rc_in), 1);
    check("and_busy_exec", 32'(busy), 1);
    step(0, 8'h00, 1, 0);
    check("and_busy_done", 32'(busy), 1);
    check("and_done_rcin", 32'(rc_in), 0);
    step(0, 8'h00, 1, 0);
    check("and_ready_again", 32'(inst_ready), 1);

    // LOAD r2 acked after 4 wait cycles
    mem_op(8'b00101_010, 4, req_n, ack_n, err_n, rcin_n);
    check("load_req_cycles", 32'(req_n), 5);
    check("load_ack_cycles", 32'(ack_n), 1);
    check("load_done_busy", 32'(busy), 1);
    step(0, 8'h00, 1, 0);
    check("load_idle_ready", 32'(inst_ready), 1);

    // STORE r1 with no ack: timeout
    mem_op(8'b00110_001, 99, req_n, ack_n, err_n, rcin_n);
    check("store_to_req_cycles", 32'(req_n), 15);
    check("store_to_err_pulses", 32'(err_n), 1);
    check("store_to_rcin", 32'(rcin_n), 0);

    // STORE acked on the timeout cycle: ack wins
    mem_op(8'b00110_100, 14, req_n, ack_n, err_n, rcin_n);
    check("store_late_req_cycles", 32'(req_n), 15);
    check("store_late_err", 32'(err_n), 0);

    // LOAD acked immediately
    mem_op(8'b00101_111, 0, req_n, ack_n, err_n, rcin_n);
    check("load_fast_req_cycles", 32'(req_n), 1);

    // Illegal opcode
    wait_idle();
    step(1, 8'b11111_000, 1, 0);
    check("illegal_pulse", 32'(illegal), 1);
    check("illegal_rout", 32'(rout), 0);
    check("illegal_rcin", 32'(rc_in), 0);
    check("illegal_alusel", 32'(alu_sel), 0);
    n = 1;
    for (int k = 0; k < 10 && !inst_ready; k++) begin
      step(0, 8'h00, 1, 0);
      n++;
      if (n == 2) check("illegal_one_cycle", 32'(illegal), 0);
    end
    check("illegal_latency", 32'(n), 3);

    // Reset during MEM of a LOAD
    wait_idle();
    step(1, 8'b00101_011, 1, 99);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    check("pre_reset_memreq", 32'(mem_req), 1);
    step(0, 8'h00, 0, 0);
    check("reset_memreq", 32'(mem_req), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_ready_low", 32'(inst_ready), 0);
    step(0, 8'h00, 1, 0);
    check("reset_ready_back", 32'(inst_ready), 1);

    // Random traffic against the schedule model
    for (int k = 0; k < 3000; k++) begin
      ri[2:0] = 3'($urandom_range(0, 7));
      ri[7:3] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(0, 13));
      step(1'($urandom_range(0, 1)), ri, ($urandom_range(0, 199) != 0),
           int'($urandom_range(0, 17)));
    end

    chk_en = 0;
    rst_n = 0;

    // Wide-instruction build
    @(posedge clk); #1;
    rst2_n = 1;
    @(posedge clk); #2;
    check("w10_ready", 32'(ready2), 1);
    inst2 = {7'b01_01101, 3'd4}; v2 = 1;
    @(posedge clk); #2;
    v2 = 0;
    check("w10_upper_illegal", 32'(ill2), 1);
    check("w10_upper_alusel", 32'(as2), 0);
    check("w10_upper_rout", 32'(rout2), 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("w10_ready2", 32'(ready2), 1);
    inst2 = {7'b00_01101, 3'd5}; v2 = 1;
    @(posedge clk); #2;
    v2 = 0;
    check("w10_inc_alusel", 32'(as2), 7);
    check("w10_inc_illegal", 32'(ill2), 0);
    check("w10_inc_regsel", 32'(rs2), 5);
    check("w10_inc_rcin", 32'(rcin2), 1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    inst2 = {7'b00_00101, 3'd0}; v2 = 1; ack2 = 0;
    @(posedge clk); #2;
    v2 = 0;
    req_n = 0; err_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      if (!req2) break;
      req_n++;
      if (err2) err_n++;
    end
    check("w10_timeout_req", 32'(req_n), 3);
    check("w10_timeout_err", 32'(err_n), 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit_seq.md
Name: control_unit_seq

Overview:
Multi-cycle, parametrised successor to the 8-bit combinational control unit.
- Accepts instructions over a valid/ready handshake and latches them into an internal instruction register (IR).
- Sequences register-file, RA/RC, ALU and constant-generator controls through a small FSM.
- Adds load/store with a memory request/acknowledge handshake, plus timeout handling and an illegal-opcode flag.
- Sits between the instruction source and the datapath (register file, RA/RC, ALU, memory port).

Parameters:
- DATA_W, 8: instruction width; opcode is the upper DATA_W-REGSEL_W bits, DATA_W-REGSEL_W >= 5.
- REGSEL_W, 3: register-select field width, taken from IR[REGSEL_W-1:0].
- ALUSEL_W, 3: ALU select width, >= 3.
- MEM_TIMEOUT, 15: maximum cycles to wait for memAck before aborting, >= 1.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- rst_n, in, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- inst, in, DATA_W: instruction word.
- instValid, in, 1: inst is valid.
- instReady, out, 1: unit can accept an instruction.
- regSel, out, REGSEL_W: register-file select.
- aluSel, out, ALUSEL_W: ALU function select.
- Rin, out, 1: register file loads from the bus.
- Rout, out, 1: register file drives the bus.
- RAin, out, 1: RA loads from the bus.
- RCin, out, 1: RC loads (ALU result or memory data).
- RCout, out, 1: RC drives the bus.
- genConst, out, 1: constant generator drives the bus.
- MARin, out, 1: memory address register loads from the bus.
- memReq, out, 1: memory request.
- memWe, out, 1: write enable, valid only while memReq=1.
- memOut, out, 1: memory drives the bus.
- memAck, in, 1: memory completes the request.
- busy, out, 1: high in every state other than IDLE.
- illegal, out, 1: one-cycle pulse on an undefined opcode.
- memErr, out, 1: one-cycle pulse on memory timeout.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; IR=0; timeout counter=0.
  - All outputs 0, including instReady.
  - instReady rises on the first edge with rst_n=1.
  - Reset mid-operation aborts immediately; memReq drops on the same edge.
- Control outputs are decoded combinationally from state and IR. Every control is 0 in IDLE, and regSel=0 in IDLE.
- Opcodes (the 5 LSBs of the opcode field; wider upper bits must be 0, otherwise the opcode is illegal):
  - 0 NOP
  - 1 MOV reg->RC
  - 2 MOV const->RC
  - 3 MOV RC->reg
  - 4 MOV reg->RA
  - 5 LOAD
  - 6 STORE
  - 7 NOT
  - 8 AND
  - 9 OR
  - 10 XOR
  - 11 ADD
  - 12 SUB
  - 13 INC
  - 14-31 illegal
- aluSel encoding: NOT=1, AND=2, OR=3, XOR=4, ADD=5, SUB=6, INC=7, otherwise 0. aluSel is held for the entire EXEC cycle.
- FSM states: IDLE, EXEC, MEM, DONE.
- IDLE:
  - instReady=1.
  - On instValid && instReady: IR<=inst, next state EXEC.
  - instValid=0 leaves the state unchanged.
- EXEC (one cycle; regSel=IR[REGSEL_W-1:0]):
  - MOV reg->RC and NOT/AND/OR/XOR/ADD/SUB/INC: Rout=1, RCin=1.
  - MOV const->RC: genConst=1, RCin=1.
  - MOV RC->reg: RCout=1, Rin=1.
  - MOV reg->RA: Rout=1, RAin=1.
  - LOAD/STORE: Rout=1, MARin=1, next state MEM. All other opcodes go to DONE.
  - NOP: no controls asserted.
  - Illegal opcode: illegal=1 for this cycle, otherwise treated as NOP.
- MEM:
  - memReq=1; memWe=1 for STORE, 0 for LOAD.
  - STORE: RCout=1 throughout MEM.
  - In the memAck cycle of a LOAD: memOut=1, RCin=1.
  - memAck=1 -> DONE, counter cleared.
  - memAck=0 -> counter increments.
  - Counter reaching MEM_TIMEOUT-1 with no ack -> memErr=1 for one cycle, RC not written, go to DONE.
  - memAck seen in the same cycle as the timeout: the ack wins and memErr=0.
- DONE: one bubble cycle, all controls 0, then IDLE.
- Latency per instruction: 3 cycles for non-memory ops; 4+wait cycles for memory ops. Throughput: one instruction per 3 cycles minimum.
- memAck outside MEM is ignored.

Decomposition:
- Shared package cu_pkg:
  - opcode localparams (OP_NOP..OP_INC);
  - ALU select constants (ALU_NONE..ALU_INC);
  - FSM state encoding (IDLE/EXEC/MEM/DONE, 2 bits).
- One sub-module, cu_op_decode: combinational IR opcode -> instruction-class flags (isAlu, isMem, isStore, isIllegal, ...) plus aluSel.
- FSM, counter and output gating stay in control_unit_seq.

Test Plan:
- Reset then inst=8'b01000_011 (AND r3) with instValid=1 -> instReady=1 at cycle 0; in cycle 1 (EXEC): regSel=3, aluSel=2, Rout=1, RCin=1; busy=1 for cycles 1-2; instReady=1 again at cycle 3.
- inst=8'b00101_010 (LOAD r2), memAck after 4 wait cycles -> EXEC: Rout=1, MARin=1; memReq=1, memWe=0 for 5 cycles; memOut=1 and RCin=1 only in the ack cycle; then DONE, then IDLE.
- STORE r1 with memAck held at 0 and MEM_TIMEOUT=15 -> memReq=1, memWe=1, RCout=1 for 15 cycles; memErr pulses once; RCin never asserted.
- inst=8'b11111_000 -> illegal=1 only in the EXEC cycle; all datapath controls 0; returns to IDLE after 3 cycles.
- rst_n=0 during MEM of a LOAD -> at the next edge memReq=0, busy=0, instReady=0; instReady=1 one cycle after rst_n returns to 1.
- DATA_W=10 build, inst with a nonzero upper opcode bit -> illegal=1; with the upper bits zero, opcode 13 (INC) gives aluSel=7.
